// File: rtl/bridge_resp_target.sv
// bridge_resp_target: target-side responder for the bridge request path.
// Forwards the arbitrated request stream to an in-order slave port and keeps
// a FIFO of granted IDs. Each in-order slave response pops the oldest ID.
// The popped ID is returned one cycle later as a registered response.
module bridge_resp_target #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH/8,
    parameter int TAG_WIDTH       = DATA_WIDTH/8,
    parameter int AUX_WIDTH       = 32,
    parameter int ID_WIDTH        = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // request side (from bridge)
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_add_i,
    input  logic                  data_wen_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [TAG_WIDTH-1:0]  data_wtag_i,
    input  logic [BE_WIDTH-1:0]   data_be_i,
    input  logic [ID_WIDTH-1:0]   data_ID_i,
    input  logic [AUX_WIDTH-1:0]  data_aux_i,
    output logic                  data_gnt_o,
    // slave side
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic                  mem_wen_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [TAG_WIDTH-1:0]  mem_wtag_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    output logic [AUX_WIDTH-1:0]  mem_aux_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i,
    // response side (to bridge)
    output logic                  data_r_valid_o,
    output logic [ID_WIDTH-1:0]   data_r_ID_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                  data_r_opc_o,
    output logic                  proto_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // Pointers wrap explicitly so that non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    logic [ID_WIDTH-1:0]   r_id_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_rvalid;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_ropc;
    logic                  r_proto_err;

    logic w_space;
    logic w_push;
    logic w_pop;
    logic w_spurious;

    // Space is judged on the registered count only: a same-cycle pop never frees a slot.
    // A response arriving with nothing outstanding is flagged rather than popped.
    always_comb begin
        w_space = (r_count < MAX_CNT);
        w_push  = data_req_i & w_space & mem_gnt_i;
        if (r_count != CNT_ZERO) begin
            w_pop      = mem_rvalid_i;
            w_spurious = 1'b0;
        end else begin
            w_pop      = 1'b0;
            w_spurious = mem_rvalid_i;
        end
    end

    assign mem_req_o   = data_req_i & w_space;
    assign data_gnt_o  = w_push;
    assign mem_add_o   = data_add_i;
    assign mem_wen_o   = data_wen_i;
    assign mem_wdata_o = data_wdata_i;
    assign mem_wtag_o  = data_wtag_i;
    assign mem_be_o    = data_be_i;
    assign mem_aux_o   = data_aux_i;

    assign data_r_valid_o = r_rvalid;
    assign data_r_ID_o    = r_rid;
    assign data_r_rdata_o = r_rdata;
    assign data_r_opc_o   = r_ropc;
    assign proto_err_o    = r_proto_err;

    // ID storage: written on every grant outside reset; contents are meaningless when not counted.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_id_mem[r_wptr] <= data_ID_i;
        end
    end

    // FIFO bookkeeping, registered response and sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= PTR_ZERO;
            r_rptr      <= PTR_ZERO;
            r_count     <= CNT_ZERO;
            r_rvalid    <= 1'b0;
            r_rid       <= {ID_WIDTH{1'b0}};
            r_rdata     <= {DATA_WIDTH{1'b0}};
            r_ropc      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr  <= next_ptr(r_rptr);
                r_rid   <= r_id_mem[r_rptr];
                r_rdata <= mem_rdata_i;
                r_ropc  <= mem_err_i;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_rvalid <= w_pop;
            if (w_spurious) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bridge_resp_target.sv
// Self-checking bench for bridge_resp_target: directed literal checks plus a
// randomized phase compared every cycle against a queue-based model.
module tb_bridge_resp_target;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW/8;
    localparam int TW  = DW/8;
    localparam int XW  = 32;
    localparam int IW  = 16;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_req_i;
    logic [AW-1:0] data_add_i;
    logic          data_wen_i;
    logic [DW-1:0] data_wdata_i;
    logic [TW-1:0] data_wtag_i;
    logic [BW-1:0] data_be_i;
    logic [IW-1:0] data_ID_i;
    logic [XW-1:0] data_aux_i;
    logic          data_gnt_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_add_o;
    logic          mem_wen_o;
    logic [DW-1:0] mem_wdata_o;
    logic [TW-1:0] mem_wtag_o;
    logic [BW-1:0] mem_be_o;
    logic [XW-1:0] mem_aux_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_err_i;
    logic          data_r_valid_o;
    logic [IW-1:0] data_r_ID_o;
    logic [DW-1:0] data_r_rdata_o;
    logic          data_r_opc_o;
    logic          proto_err_o;

    bridge_resp_target #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_WIDTH(TW),
        .AUX_WIDTH(XW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
        .data_wdata_i(data_wdata_i), .data_wtag_i(data_wtag_i), .data_be_i(data_be_i),
        .data_ID_i(data_ID_i), .data_aux_i(data_aux_i), .data_gnt_o(data_gnt_o),
        .mem_req_o(mem_req_o), .mem_add_o(mem_add_o), .mem_wen_o(mem_wen_o),
        .mem_wdata_o(mem_wdata_o), .mem_wtag_o(mem_wtag_o), .mem_be_o(mem_be_o),
        .mem_aux_o(mem_aux_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .data_r_valid_o(data_r_valid_o), .data_r_ID_o(data_r_ID_o),
        .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [IW-1:0] q[$];
    logic          m_valid;
    logic [IW-1:0] m_id;
    logic [DW-1:0] m_rdata;
    logic          m_opc;
    logic          m_proto;
    bit            m_ready = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_valid = 1'b0; m_id = '0; m_rdata = '0; m_opc = 1'b0; m_proto = 1'b0;
                m_ready = 1'b1;
            end else if (m_ready) begin
                bit g;
                g = data_req_i && (q.size() < MAX) && mem_gnt_i;
                m_valid = 1'b0;
                if (mem_rvalid_i) begin
                    if (q.size() > 0) begin
                        m_id    = q.pop_front();
                        m_rdata = mem_rdata_i;
                        m_opc   = mem_err_i;
                        m_valid = 1'b1;
                    end else begin
                        m_proto = 1'b1;
                    end
                end
                if (g) q.push_back(data_ID_i);
            end
        end
    end

    // Compare everything mid-cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_ready) begin
                chk("mem_req", 64'(mem_req_o), 64'(data_req_i && (q.size() < MAX)));
                chk("gnt", 64'(data_gnt_o), 64'(data_req_i && (q.size() < MAX) && mem_gnt_i));
                chk("fwd_add", 64'(mem_add_o), 64'(data_add_i));
                chk("fwd_wdata", 64'(mem_wdata_o), 64'(data_wdata_i));
                chk("fwd_misc", 64'({mem_wen_o, mem_be_o, mem_wtag_o}),
                    64'({data_wen_i, data_be_i, data_wtag_i}));
                chk("fwd_aux", 64'(mem_aux_o), 64'(data_aux_i));
                chk("r_valid", 64'(data_r_valid_o), 64'(m_valid));
                chk("r_ID", 64'(data_r_ID_o), 64'(m_id));
                chk("r_rdata", 64'(data_r_rdata_o), 64'(m_rdata));
                chk("r_opc", 64'(data_r_opc_o), 64'(m_opc));
                chk("proto_err", 64'(proto_err_o), 64'(m_proto));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_req_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    endtask

    task automatic push(input logic [IW-1:0] id);
        data_req_i = 1'b1; data_ID_i = id; mem_gnt_i = 1'b1;
        tick();
        data_req_i = 1'b0;
    endtask

    task automatic pop_expect(input string nm, input logic [IW-1:0] id, input logic [DW-1:0] rd);
        mem_rvalid_i = 1'b1; mem_rdata_i = rd;
        tick();
        mem_rvalid_i = 1'b0;
        chk({nm, "_valid"}, 64'(data_r_valid_o), 64'd1);
        chk({nm, "_id"}, 64'(data_r_ID_o), 64'(id));
    endtask

    logic [IW-1:0] exp_ids [4];

    initial begin
        rst = 1'b1; data_req_i = 1'b0; data_add_i = 32'h0; data_wen_i = 1'b1;
        data_wdata_i = 32'h0; data_wtag_i = 4'h0; data_be_i = 4'hF; data_ID_i = 16'h0;
        data_aux_i = 32'h0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        mem_err_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_valid", 64'(data_r_valid_o), 64'd0);
        chk("reset_proto", 64'(proto_err_o), 64'd0);
        chk("reset_id", 64'(data_r_ID_o), 64'd0);

        // Single read: grant at cycle 0, rvalid at cycle 2, response at cycle 3.
        data_req_i = 1'b1; data_ID_i = 16'h0004; #1;
        chk("single_gnt", 64'(data_gnt_o), 64'd1);
        tick(); data_req_i = 1'b0;
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        tick(); mem_rvalid_i = 1'b0;
        chk("single_valid", 64'(data_r_valid_o), 64'd1);
        chk("single_id", 64'(data_r_ID_o), 64'h0004);
        chk("single_rdata", 64'(data_r_rdata_o), 64'hDEADBEEF);
        chk("single_opc", 64'(data_r_opc_o), 64'd0);
        tick();
        chk("single_pulse", 64'(data_r_valid_o), 64'd0);
        chk("single_hold", 64'(data_r_ID_o), 64'h0004);

        // Back-to-back.
        exp_ids[0] = 16'h0001; exp_ids[1] = 16'h0002; exp_ids[2] = 16'h0004; exp_ids[3] = 16'h0008;
        for (int i = 0; i < 4; i++) push(exp_ids[i]);
        tick();
        for (int i = 0; i < 4; i++) pop_expect("b2b", exp_ids[i], 32'(i));

        // Full.
        for (int i = 0; i < 4; i++) push(exp_ids[i]);
        data_req_i = 1'b1; data_ID_i = 16'h0020; #1;
        chk("full_gnt", 64'(data_gnt_o), 64'd0);
        chk("full_req", 64'(mem_req_o), 64'd0);
        mem_rvalid_i = 1'b1; #1;
        chk("full_pop_nogrant", 64'(data_gnt_o), 64'd0);
        tick(); mem_rvalid_i = 1'b0;
        chk("full_pop_id", 64'(data_r_ID_o), 64'h0001);
        chk("full_resume", 64'(data_gnt_o), 64'd1);
        tick(); data_req_i = 1'b0;
        pop_expect("full_drain0", 16'h0002, 32'h0);
        pop_expect("full_drain1", 16'h0004, 32'h0);
        pop_expect("full_drain2", 16'h0008, 32'h0);
        pop_expect("full_drain3", 16'h0020, 32'h0);

        // Simultaneous push and pop at count 2.
        push(16'h0040); push(16'h0080);
        data_req_i = 1'b1; data_ID_i = 16'h0010; mem_rvalid_i = 1'b1;
        tick(); data_req_i = 1'b0; mem_rvalid_i = 1'b0;
        chk("simul_id", 64'(data_r_ID_o), 64'h0040);
        pop_expect("simul_next", 16'h0080, 32'h0);
        pop_expect("simul_last", 16'h0010, 32'h0);

        // Error response then spurious response.
        push(16'h0002);
        mem_err_i = 1'b1;
        pop_expect("err", 16'h0002, 32'h5);
        mem_err_i = 1'b0;
        chk("err_opc", 64'(data_r_opc_o), 64'd1);
        mem_rvalid_i = 1'b1;
        tick(); mem_rvalid_i = 1'b0;
        chk("spur_valid", 64'(data_r_valid_o), 64'd0);
        chk("spur_proto", 64'(proto_err_o), 64'd1);
        tick(); tick();
        chk("spur_sticky", 64'(proto_err_o), 64'd1);

        // Reset mid-operation.
        push(16'h0100); push(16'h0200); push(16'h0400);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rst_valid", 64'(data_r_valid_o), 64'd0);
        chk("rst_id", 64'(data_r_ID_o), 64'd0);
        chk("rst_rdata", 64'(data_r_rdata_o), 64'd0);
        chk("rst_opc", 64'(data_r_opc_o), 64'd0);
        chk("rst_proto", 64'(proto_err_o), 64'd0);
        mem_rvalid_i = 1'b1;
        tick(); mem_rvalid_i = 1'b0;
        chk("rst_spur_valid", 64'(data_r_valid_o), 64'd0);
        chk("rst_spur_proto", 64'(proto_err_o), 64'd1);
        data_req_i = 1'b1; data_ID_i = 16'h0800; #1;
        chk("rst_regrant", 64'(data_gnt_o), 64'd1);
        tick(); data_req_i = 1'b0;
        pop_expect("rst_newpop", 16'h0800, 32'h77);

        // Randomized phase, checked every cycle by the model compare process.
        for (int c = 0; c < 3000; c++) begin
            data_req_i   = ($urandom_range(0, 99) < 60);
            data_add_i   = $urandom;
            data_wen_i   = $urandom_range(0, 1) == 1;
            data_wdata_i = $urandom;
            data_wtag_i  = 4'($urandom);
            data_be_i    = 4'($urandom);
            data_ID_i    = 16'h0001 << $urandom_range(0, 15);
            data_aux_i   = $urandom;
            mem_gnt_i    = ($urandom_range(0, 99) < 70);
            if (q.size() > 0) mem_rvalid_i = ($urandom_range(0, 99) < 45);
            else              mem_rvalid_i = ($urandom_range(0, 99) < 2);
            mem_rdata_i  = $urandom;
            mem_err_i    = ($urandom_range(0, 99) < 10);
            rst          = ($urandom_range(0, 999) < 4);
            tick();
        end
        rst = 1'b0;
        idle();
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
